// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch.
package stopwatch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} sw_state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX      = 4'd9;
  localparam bcd_t SEC_TENS_MAX = 4'd5;

  // Most significant digit first so the packed value reads as MMSShh in hex.
  typedef struct packed {
    bcd_t min_tens;
    bcd_t min_ones;
    bcd_t sec_tens;
    bcd_t sec_ones;
    bcd_t hun_tens;
    bcd_t hun_ones;
  } sw_time_t;

  function automatic bcd_t bcd_inc(bcd_t d);
    return (d == BCD_MAX) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous level followed by a one-clock rising-edge pulse.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic in_edge
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign in_edge = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/stopwatch_bcd.sv
// MM:SS.hh BCD stopwatch counting synchronised tick edges, with start/stop/clear control.
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_MIN     = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tickIn,
  input  logic       startStop,
  input  logic       clear,
  output logic       running,
  output logic [3:0] minTens,
  output logic [3:0] minOnes,
  output logic [3:0] secTens,
  output logic [3:0] secOnes,
  output logic [3:0] hunTens,
  output logic [3:0] hunOnes,
  output logic       rollover
);

  localparam bcd_t MIN_TENS_MAX = bcd_t'(MAX_MIN / 10);
  localparam bcd_t MIN_ONES_MAX = bcd_t'(MAX_MIN % 10);

  logic      tick_edge, ss_edge, clr_edge;
  sw_state_t state_q, state_d;
  sw_time_t  time_q, time_d;
  logic      running_q, rollover_q, rollover_d;
  logic      inc, carry_hun_ones, carry_hun, carry_sec_ones, carry_sec, min_at_max;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_tick (
    .clk     (clk),
    .reset   (reset),
    .in      (tickIn),
    .in_edge (tick_edge)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
    .clk     (clk),
    .reset   (reset),
    .in      (startStop),
    .in_edge (ss_edge)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clr (
    .clk     (clk),
    .reset   (reset),
    .in      (clear),
    .in_edge (clr_edge)
  );

  always_comb begin
    state_d = state_q;
    if (clr_edge) begin
      state_d = IDLE;
    end else if (ss_edge) begin
      unique case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Clear outranks a coincident tick, so it also blocks the increment.
  assign inc            = (state_q == RUN) && tick_edge && !clr_edge;
  assign carry_hun_ones = inc && (time_q.hun_ones == BCD_MAX);
  assign carry_hun      = carry_hun_ones && (time_q.hun_tens == BCD_MAX);
  assign carry_sec_ones = carry_hun && (time_q.sec_ones == BCD_MAX);
  assign carry_sec      = carry_sec_ones && (time_q.sec_tens == SEC_TENS_MAX);
  assign min_at_max     = (time_q.min_tens == MIN_TENS_MAX) && (time_q.min_ones == MIN_ONES_MAX);

  always_comb begin
    time_d     = time_q;
    rollover_d = 1'b0;
    if (clr_edge) begin
      time_d = '0;
    end else if (inc) begin
      time_d.hun_ones = bcd_inc(time_q.hun_ones);
      if (carry_hun_ones) time_d.hun_tens = bcd_inc(time_q.hun_tens);
      if (carry_hun)      time_d.sec_ones = bcd_inc(time_q.sec_ones);
      if (carry_sec_ones) time_d.sec_tens = carry_sec ? 4'd0 : time_q.sec_tens + 4'd1;
      if (carry_sec) begin
        if (min_at_max) begin
          time_d.min_tens = 4'd0;
          time_d.min_ones = 4'd0;
          rollover_d      = 1'b1;
        end else if (time_q.min_ones == BCD_MAX) begin
          time_d.min_ones = 4'd0;
          time_d.min_tens = time_q.min_tens + 4'd1;
        end else begin
          time_d.min_ones = time_q.min_ones + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      time_q     <= '0;
      running_q  <= 1'b0;
      rollover_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      time_q     <= time_d;
      running_q  <= (state_d == RUN);
      rollover_q <= rollover_d;
    end
  end

  assign running  = running_q;
  assign rollover = rollover_q;
  assign minTens  = time_q.min_tens;
  assign minOnes  = time_q.min_ones;
  assign secTens  = time_q.sec_tens;
  assign secOnes  = time_q.sec_ones;
  assign hunTens  = time_q.hun_tens;
  assign hunOnes  = time_q.hun_ones;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Scoreboard bench for stopwatch_bcd: a hundredths-count model predicts display and run state.
module tb_stopwatch_bcd;

  localparam int MAX_MIN = 59;
  localparam int WRAP    = (MAX_MIN + 1) * 6000;
  localparam logic [3:0] MT_MAX = 4'(MAX_MIN / 10);

  logic clk = 1'b0, reset = 1'b0, tickIn = 1'b0, startStop = 1'b0, clear = 1'b0;
  logic running, rollover;
  logic [3:0] minTens, minOnes, secTens, secOnes, hunTens, hunOnes;
  logic [23:0] disp;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;
  bit exp_run  = 1'b0;

  typedef struct {
    string       name;
    logic [23:0] digits;
    logic        run;
  } exp_t;
  exp_t sb_q[$];

  always #10 clk = ~clk;

  stopwatch_bcd #(.SYNC_STAGES(2), .MAX_MIN(MAX_MIN)) dut (
    .clk       (clk),
    .reset     (reset),
    .tickIn    (tickIn),
    .startStop (startStop),
    .clear     (clear),
    .running   (running),
    .minTens   (minTens),
    .minOnes   (minOnes),
    .secTens   (secTens),
    .secOnes   (secOnes),
    .hunTens   (hunTens),
    .hunOnes   (hunOnes),
    .rollover  (rollover)
  );

  assign disp = {minTens, minOnes, secTens, secOnes, hunTens, hunOnes};

  function automatic logic [23:0] to_bcd(int c);
    int m, s, h;
    m = c / 6000;
    s = (c / 100) % 60;
    h = c % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(h / 10), 4'(h % 10)};
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      n_checks++;
      if (hunOnes > 4'd9 || hunTens > 4'd9 || secOnes > 4'd9 || secTens > 4'd5 ||
          minOnes > 4'd9 || minTens > MT_MAX) begin
        n_fail++;
        $display("FAIL digit_range: got %h, a digit is above its maximum", disp);
      end
    end
  end

  task automatic push_exp(string name);
    exp_t e;
    e.name   = name;
    e.digits = to_bcd(exp_cnt);
    e.run    = exp_run;
    sb_q.push_back(e);
  endtask

  task automatic check_sb();
    exp_t e;
    repeat (4) @(negedge clk);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_checks++;
      if (disp !== e.digits) begin
        n_fail++;
        $display("FAIL %s digits: got %h expected %h", e.name, disp, e.digits);
      end
      n_checks++;
      if (running !== e.run) begin
        n_fail++;
        $display("FAIL %s running: got %b expected %b", e.name, running, e.run);
      end
    end
  endtask

  // One-clock-high pulse on any combination of inputs, then one clock low.
  task automatic pulse(bit t, bit s, bit c);
    @(negedge clk);
    tickIn = t; startStop = s; clear = c;
    @(negedge clk);
    tickIn = 1'b0; startStop = 1'b0; clear = 1'b0;
    if (c) begin
      exp_cnt = 0;
      exp_run = 1'b0;
    end else begin
      if (t && exp_run) exp_cnt = (exp_cnt + 1) % WRAP;
      if (s) exp_run = !exp_run;
    end
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) pulse(1'b1, 1'b0, 1'b0);
  endtask

  task automatic preload(logic [23:0] v, int cnt);
    force dut.time_q = v;
    @(posedge clk);
    @(negedge clk);
    release dut.time_q;
    exp_cnt = cnt;
  endtask

  task automatic async_reset_check(string name);
    @(negedge clk);
    #3 reset = 1'b0;
    #1;
    n_checks++;
    if (disp !== 24'h0) begin
      n_fail++;
      $display("FAIL %s digits: got %h expected 000000", name, disp);
    end
    n_checks++;
    if (running !== 1'b0 || rollover !== 1'b0) begin
      n_fail++;
      $display("FAIL %s flags: got running=%b rollover=%b expected 0 0", name, running, rollover);
    end
    @(negedge clk);
    reset   = 1'b1;
    exp_cnt = 0;
    exp_run = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (disp !== 24'h0 || running !== 1'b0 || rollover !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %h run=%b roll=%b expected 000000 0 0",
               disp, running, rollover);
    end
    reset = 1'b1;
  endtask

  task automatic test_count();
    @(negedge clk);
    startStop = 1'b1;
    exp_run   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (running !== 1'b0) begin
      n_fail++;
      $display("FAIL ss_latency_early: got running=%b expected 0", running);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (running !== 1'b1) begin
      n_fail++;
      $display("FAIL ss_latency: got running=%b expected 1", running);
    end
    @(negedge clk);
    startStop = 1'b0;
    ticks(250);
    push_exp("count_250");
    check_sb();
  endtask

  task automatic test_pause();
    ticks(250);
    push_exp("count_500");
    check_sb();
    pulse(1'b0, 1'b1, 1'b0);
    ticks(40);
    push_exp("pause_hold");
    check_sb();
    pulse(1'b0, 1'b1, 1'b0);
    ticks(1);
    push_exp("resume_one");
    check_sb();
  endtask

  task automatic test_reset_mid_run();
    async_reset_check("reset_pre");
    pulse(1'b0, 1'b1, 1'b0);
    ticks(1234);
    push_exp("count_1234");
    check_sb();
    async_reset_check("reset_mid_run");
    ticks(1);
    push_exp("idle_after_reset");
    check_sb();
  endtask

  task automatic test_rollover();
    int hi = 0;
    pulse(1'b0, 1'b1, 1'b0);
    preload(24'h595999, WRAP - 1);
    @(negedge clk);
    tickIn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tickIn = 1'b0;
      if (rollover === 1'b1) begin
        hi++;
        n_checks++;
        if (disp !== 24'h0 || running !== 1'b1) begin
          n_fail++;
          $display("FAIL rollover_state: got %h run=%b expected 000000 1", disp, running);
        end
      end
    end
    n_checks++;
    if (hi !== 1) begin
      n_fail++;
      $display("FAIL rollover_width: got %0d cycles expected 1", hi);
    end
    exp_cnt = (exp_cnt + 1) % WRAP;
    push_exp("after_wrap");
    check_sb();
  endtask

  task automatic test_simultaneous();
    ticks(7);
    push_exp("count_7");
    check_sb();
    pulse(1'b1, 1'b0, 1'b1);
    push_exp("tick_and_clear");
    check_sb();
    pulse(1'b0, 1'b1, 1'b0);
    ticks(3);
    pulse(1'b0, 1'b1, 1'b1);
    push_exp("ss_and_clear");
    check_sb();
    pulse(1'b0, 1'b1, 1'b0);
    ticks(2);
    pulse(1'b1, 1'b1, 1'b0);
    push_exp("tick_ss_in_run");
    check_sb();
    pulse(1'b1, 1'b1, 1'b0);
    push_exp("tick_ss_in_pause");
    check_sb();
    ticks(1);
    push_exp("first_tick_after_resume");
    check_sb();
  endtask

  task automatic test_digit_boundaries();
    preload(24'h000999, 999);
    ticks(1);
    push_exp("sec_carry");
    check_sb();
    preload(24'h095999, 59999);
    ticks(1);
    push_exp("min_carry");
    check_sb();
  endtask

  initial begin
    test_reset();
    test_count();
    test_pause();
    test_reset_mid_run();
    test_rollover();
    test_simultaneous();
    test_digit_boundaries();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
